register_pipe_nbit: RTL
=======================

// Module: register_pipe_nbit
// PURPOSE
//  Parametrised successor to the fixed 10-bit clocked register: a WIDTH-bit, DEPTH-stage
//  register pipeline with valid/ready flow control and bubble collapsing.
//  Sits between datapath blocks to retime buses and absorb downstream stalls
//  without dropping or duplicating words.
// PARAMETERS
//  WIDTH  10  data bus width in bits (>=1)
//  DEPTH  4   number of register stages (>=1)
//  CW     $clog2(DEPTH+1)  occupancy counter width (derived, localparam)
// PORTS
//  clk        in   1      rising-edge clock, the only clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      upstream word present on data_in
//  in_ready   out  1      pipeline can accept a word this cycle
//  data_in    in   WIDTH  upstream data
//  out_valid  out  1      word present on data_out
//  out_ready  in   1      downstream takes data_out this cycle
//  data_out   out  WIDTH  last-stage data
//  occupancy  out  CW     number of valid stages, 0..DEPTH
//  flush      in   1      (only with REGISTER_PIPE_FLUSH_EN) drop all contents
// BEHAVIOUR
//  - Stages s[0..DEPTH-1], each holds data d[i] and flag v[i]. s[0] is input side,
//    s[DEPTH-1] drives data_out/out_valid directly (registered outputs, no comb path in->out).
//  - adv[DEPTH] = out_ready; adv[i] = !v[i] | adv[i+1]  (stage i may load).
//  - in_ready = adv[0] (combinational from out_ready through the chain; no registered
//    ready). Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - At each edge where adv[i]: v[i] <= (i==0 ? in_valid : v[i-1]),
//    d[i] <= (i==0 ? data_in : d[i-1]) only when the incoming flag is 1; else d[i] holds.
//    Stages with adv[i]=0 hold both data and flag.
//  - Bubbles collapse: an empty stage always loads, so gaps close while the output stalls.
//  - Latency: unstalled, a word accepted at edge k is in s[DEPTH-1] after edge k+DEPTH-1
//    (DEPTH=1: visible on data_out right after the accept edge). Throughput 1 word/cycle.
//  - occupancy = popcount(v), registered: +1 on transfer in, -1 on transfer out,
//    unchanged when both or neither occur in the same cycle.
//  - Full (occupancy==DEPTH) with out_ready=0: in_ready=0, nothing moves.
//    Full with out_ready=1: simultaneous in and out accepted, occupancy stays DEPTH.
//  - Empty: out_valid=0, data_out holds last value; in_ready=1.
//  - data_in ignored when in_valid=0; data_out must not change while out_valid & !out_ready.
//  - Reset (any time, incl. mid-stream): all v[i]=0, all d[i]=0, data_out=0,
//    out_valid=0, occupancy=0; in_ready reads 1 in the cycle after reset releases.
//    In-flight words are discarded; no transfers are counted during reset cycles.
// CONFIGURATION
//  - REGISTER_PIPE_FLUSH_EN defined: port flush exists. flush=1 at an edge clears all
//    v[i] and occupancy to 0 (data regs hold); a word offered in that cycle is
//    not accepted (in_ready forced 0 while flush=1). rst has priority over flush.
//  - Not defined: no flush port; contents only cleared by rst.
// TESTING (WIDTH=10, DEPTH=4 unless noted)
//  1 rst=1 2 cycles, release -> data_out=0, out_valid=0, occupancy=0, in_ready=1.
//  2 out_ready=1, stream 1,2,4,...,512 one per cycle -> same order on data_out, first
//    word valid 3 edges after its accept edge, one per cycle, no gaps.
//  3 out_ready=0, offer 5 words -> 4 accepted, in_ready=0, occupancy=4; out_ready=1
//    for 1 cycle with in_valid=1 -> one out, one in, occupancy stays 4.
//  4 insert bubble (in_valid=0 one cycle) then stall output 3 cycles -> bubble
//    collapsed, occupancy counts only valid words, order preserved.
//  5 rst=1 mid-stream with occupancy=3 -> next cycle all outputs at reset values.
//  6 FLUSH_EN build: occupancy=4, flush=1 with in_valid=1 -> occupancy=0,
//    out_valid=0, offered word dropped; DEPTH=1 build repeats tests 2-3.

Source files
------------

// File: rtl/register_pipe_nbit.sv
// WIDTH-bit, DEPTH-stage valid/ready register pipeline with bubble collapsing.
// Optional flush port enabled by defining REGISTER_PIPE_FLUSH_EN.
module register_pipe_nbit #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] data_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] data_out_o,
`ifdef REGISTER_PIPE_FLUSH_EN
  input  logic             flush_i,
`endif
  output logic [CW-1:0]    occupancy_o
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    occ_q, occ_d;

  logic [DEPTH-1:0] adv;
  logic             advAcc;
  logic [DEPTH-1:0] srcV;
  logic [WIDTH-1:0] srcD [DEPTH];
  logic             flushReq;
  logic             xferIn;
  logic             xferOut;

`ifdef REGISTER_PIPE_FLUSH_EN
  assign flushReq = flush_i;
`else
  assign flushReq = 1'b0;
`endif

  // A stage may load when it is empty or everything downstream of it moves.
  always_comb begin
    adv    = '0;
    advAcc = out_ready_i;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      advAcc = advAcc | ~v_q[i];
      adv[i] = advAcc;
    end
  end

  assign in_ready_o  = adv[0] & ~flushReq;
  assign xferIn      = in_valid_i & in_ready_o;
  assign xferOut     = v_q[DEPTH-1] & out_ready_i;
  assign out_valid_o = v_q[DEPTH-1];
  assign data_out_o  = d_q[DEPTH-1];
  assign occupancy_o = occ_q;

  always_comb begin
    v_d     = v_q;
    d_d     = d_q;
    occ_d   = occ_q;
    srcV    = '0;
    srcD[0] = data_in_i;
    srcV[0] = in_valid_i;
    for (int i = 1; i < DEPTH; i++) begin
      srcV[i] = v_q[i-1];
      srcD[i] = d_q[i-1];
    end

    // Data registers only capture real words so empty stages keep their last value.
    for (int i = 0; i < DEPTH; i++) begin
      if (adv[i] && !flushReq) begin
        v_d[i] = srcV[i];
        if (srcV[i]) begin
          d_d[i] = srcD[i];
        end
      end
    end

    if (xferIn && !xferOut) begin
      occ_d = occ_q + CW'(1);
    end else if (xferOut && !xferIn) begin
      occ_d = occ_q - CW'(1);
    end

    if (flushReq) begin
      v_d   = '0;
      occ_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      d_q   <= d_d;
    end
  end

endmodule
